// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg: shared types and constants for the adder sequencing stage
package adder_ctrl_pkg;
  localparam int ADDER_WIDTH = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
endpackage

// File: rtl/adder_accumulate_ctrl_button_sync.sv
// button_sync: button conditioner; with ADDER_CTRL_SYNC_INPUTS_EN a 2-flop synchronizer
// feeds an edge register, otherwise the raw input feeds it directly
module button_sync #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic lvl;
  logic prev_q;
`ifdef ADDER_CTRL_SYNC_INPUTS_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], d_i};
  assign lvl = sync_q[1];
`else
  assign lvl = d_i;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else prev_q <= lvl;
  // EDGE selects a one-cycle rise pulse instead of the conditioned level
  assign q_o = EDGE ? (lvl & ~prev_q) : lvl;
endmodule

// File: rtl/adder_accumulate_ctrl.sv
// adder_accumulate_ctrl: holds A/B for an external adder, waits SETTLE_CYCLES, captures Sum/CO into A.
// Define ADDER_CTRL_SYNC_INPUTS_EN to synchronize LoadB/ClearA/Run (adds 2 cycles of input latency).
module adder_accumulate_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] SW,
  input  logic             LoadB,
  input  logic             ClearA,
  input  logic             Run,
  input  logic [WIDTH-1:0] Sum_in,
  input  logic             CO_in,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             CO_flag,
  output logic             Busy,
  output logic             Done
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic co_q, co_d;
  logic load_b, clear_a, run_rise;
  button_sync #(.EDGE(1'b0)) u_load  (.clk(Clk), .rst_n(Reset_n), .d_i(LoadB),  .q_o(load_b));
  button_sync #(.EDGE(1'b0)) u_clear (.clk(Clk), .rst_n(Reset_n), .d_i(ClearA), .q_o(clear_a));
  button_sync #(.EDGE(1'b1)) u_run   (.clk(Clk), .rst_n(Reset_n), .d_i(Run),    .q_o(run_rise));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    co_d    = co_q;
    case (state_q)
      IDLE: begin
        // a Run edge starts the add and blocks operand updates in the same cycle
        if (run_rise) begin
          state_d = EXEC;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          if (load_b) b_d = SW;
          if (clear_a) begin
            a_d  = '0;
            co_d = 1'b0;
          end
        end
      end
      EXEC: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          a_d     = Sum_in;
          co_d    = CO_in;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      co_q    <= co_d;
    end
  assign A_out   = a_q;
  assign B_out   = b_q;
  assign CO_flag = co_q;
  assign Busy    = (state_q == EXEC);
  assign Done    = (state_q == DONE);
endmodule

// File: tb/tb_adder_accumulate_ctrl.sv
// tb_adder_accumulate_ctrl: directed vectors against an ideal adder model (Sum/CO = A_out + B_out)
module tb_adder_accumulate_ctrl;
`ifdef ADDER_CTRL_SYNC_INPUTS_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int SETTLE = 2;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [15:0] SW = '0;
  logic LoadB = 1'b0, ClearA = 1'b0, Run = 1'b0;
  logic [15:0] Sum_in, A_out, B_out;
  logic CO_in, CO_flag, Busy, Done;
  int n_cmp = 0, n_bad = 0;
  int ndone, first;
  logic busy_seen;
  adder_accumulate_ctrl #(.WIDTH(16), .SETTLE_CYCLES(SETTLE)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .SW(SW), .LoadB(LoadB), .ClearA(ClearA), .Run(Run),
    .Sum_in(Sum_in), .CO_in(CO_in), .A_out(A_out), .B_out(B_out), .CO_flag(CO_flag),
    .Busy(Busy), .Done(Done)
  );
  assign {CO_in, Sum_in} = {1'b0, A_out} + {1'b0, B_out};
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask
  task automatic load_b(input logic [15:0] v);
    SW = v;
    LoadB = 1'b1;
    tick(1);
    LoadB = 1'b0;
    tick(2 + SL);
  endtask
  task automatic clear_a();
    ClearA = 1'b1;
    tick(1);
    ClearA = 1'b0;
    tick(2 + SL);
  endtask
  // press Run for 'hold' cycles and watch a fixed window for Done pulses
  task automatic run_add(input int hold, output int nd, output int fst, output logic bs);
    Run = 1'b1;
    nd = 0;
    fst = -1;
    bs = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      if (Done) begin
        nd++;
        if (fst < 0) fst = n;
      end
      if (n == 1 + SL) bs = Busy;
      if (n == hold) Run = 1'b0;
    end
  endtask
  initial begin
    tick(3);
    chk("rst_a", A_out, 16'h0);
    chk("rst_b", B_out, 16'h0);
    chk("rst_co", CO_flag, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    Reset_n = 1'b1;
    tick(2);
    load_b(16'h0001);
    chk("t1_b", B_out, 16'h0001);
    run_add(1, ndone, first, busy_seen);
    chk("t1_busy", busy_seen, 1'b1);
    chk("t1_ndone", ndone, 1);
    chk("t1_lat", first, SETTLE + 1 + SL);
    chk("t1_a", A_out, 16'h0001);
    chk("t1_co", CO_flag, 1'b0);
    run_add(1, ndone, first, busy_seen);
    chk("t1_a2", A_out, 16'h0002);
    clear_a();
    chk("t2_clr0", A_out, 16'h0000);
    run_add(1, ndone, first, busy_seen);
    chk("t2_a1", A_out, 16'h0001);
    load_b(16'hFFFF);
    chk("t2_b", B_out, 16'hFFFF);
    run_add(1, ndone, first, busy_seen);
    chk("t2_wrap", A_out, 16'h0000);
    chk("t2_co", CO_flag, 1'b1);
    clear_a();
    chk("t2_clr_a", A_out, 16'h0000);
    chk("t2_clr_co", CO_flag, 1'b0);
    load_b(16'h0003);
    run_add(20, ndone, first, busy_seen);
    chk("t3_ndone", ndone, 1);
    chk("t3_a", A_out, 16'h0003);
    run_add(1, ndone, first, busy_seen);
    chk("t3_a2", A_out, 16'h0006);
    // operand changes and a second Run edge land while the add is in EXEC
    Run = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      if (Done) ndone++;
      if (n == 1) begin
        SW = 16'h1234;
        LoadB = 1'b1;
        ClearA = 1'b1;
        Run = 1'b0;
      end
      if (n == 2) begin
        LoadB = 1'b0;
        ClearA = 1'b0;
        Run = 1'b1;
      end
      if (n == 10) Run = 1'b0;
    end
    chk("t4_ndone", ndone, 1);
    chk("t4_b", B_out, 16'h0003);
    chk("t4_a", A_out, 16'h0009);
    Run = 1'b1;
    tick(1 + SL);
    chk("t5_busy", Busy, 1'b1);
    #2 Reset_n = 1'b0;
    #1;
    chk("t5_a", A_out, 16'h0);
    chk("t5_b", B_out, 16'h0);
    chk("t5_co", CO_flag, 1'b0);
    chk("t5_busy0", Busy, 1'b0);
    chk("t5_done0", Done, 1'b0);
    Run = 1'b0;
    tick(2);
    Reset_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    chk("t5_nodone", ndone, 0);
    load_b(16'h0005);
    run_add(1, ndone, first, busy_seen);
    chk("t5_lat", first, SETTLE + 1 + SL);
    chk("t5_a_new", A_out, 16'h0005);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
